// File: rtl/systolic_skew_feeder.sv
// Skews unskewed row/column operand beats into a systolic array: lane k is delayed k+1 cycles,
// with a FLUSH phase that drains the last beat before the next tile may start.
module systolic_skew_feeder #(
    parameter int ARR_SIZE      = 4,
    parameter int HORIZONTAL_BW = 16,
    parameter int VERTICAL_BW   = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic                              s_last,
    input  logic [HORIZONTAL_BW*ARR_SIZE-1:0] s_horiz,
    input  logic [VERTICAL_BW*ARR_SIZE-1:0]   s_vert,
    output logic [HORIZONTAL_BW*ARR_SIZE-1:0] horizontal_input,
    output logic [VERTICAL_BW*ARR_SIZE-1:0]   vertical_input,
    output logic                              o_busy,
    output logic                              o_done,
    output logic [15:0]                       o_beat_cnt
);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    localparam int FC_W = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;
    localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(ARR_SIZE - 1);

    state_t            state_q, state_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [15:0]       beat_cnt_q, beat_cnt_d;
    logic              accept;
    logic              flush_last;

    assign accept     = s_valid && s_ready;
    assign flush_last = (flush_cnt_q == FLUSH_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = '0;
        beat_cnt_d  = beat_cnt_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = s_last ? FLUSH : STREAM;
            STREAM:  if (accept && s_last) state_d = FLUSH;
            FLUSH: begin
                if (flush_last) state_d = IDLE;
                else            flush_cnt_d = flush_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            if (state_q == IDLE)             beat_cnt_d = 16'd1;
            else if (beat_cnt_q != 16'hFFFF) beat_cnt_d = beat_cnt_q + 16'd1;
        end
    end

    always_comb begin
        s_ready = (state_q != FLUSH);
        o_busy  = (state_q != IDLE);
        o_done  = (state_q == FLUSH) && flush_last;
    end

    assign o_beat_cnt = beat_cnt_q;

    // Free-running skew chains: no stall, bubbles enter as zeros so they add nothing to the MAC.
    for (genvar k = 0; k < ARR_SIZE; k++) begin : g_lane
        logic [HORIZONTAL_BW-1:0] h_q [k+1];
        logic [VERTICAL_BW-1:0]   v_q [k+1];
        logic [HORIZONTAL_BW-1:0] h_d;
        logic [VERTICAL_BW-1:0]   v_d;

        assign h_d = accept ? s_horiz[k*HORIZONTAL_BW +: HORIZONTAL_BW] : '0;
        assign v_d = accept ? s_vert[k*VERTICAL_BW +: VERTICAL_BW]       : '0;

        // NOTE: the skew chains are reset so in-flight operands are discarded, not leaked into the array.
        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int j = 0; j <= k; j++) begin
                    h_q[j] <= '0;
                    v_q[j] <= '0;
                end
            end else begin
                h_q[0] <= h_d;
                v_q[0] <= v_d;
                for (int j = 1; j <= k; j++) begin
                    h_q[j] <= h_q[j-1];
                    v_q[j] <= v_q[j-1];
                end
            end
        end

        assign horizontal_input[k*HORIZONTAL_BW +: HORIZONTAL_BW] = h_q[k];
        assign vertical_input[k*VERTICAL_BW +: VERTICAL_BW]       = v_q[k];
    end

endmodule

// File: doc/systolic_skew_feeder.md
SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 SHALL have parameter ARR_SIZE, default 4, meaning systolic array dimension (lanes per side).
REQ-002 SHALL have parameter HORIZONTAL_BW, default 16, meaning width of one horizontal (row) operand element.
REQ-003 SHALL have parameter VERTICAL_BW, default 32, meaning width of one vertical (column) operand element.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  meaning synchronous, active-low reset.
REQ-006 SHALL have port s_valid  input  1  meaning upstream beat valid.
REQ-007 SHALL have port s_ready  output  1  meaning feeder accepts a beat this cycle.
REQ-008 SHALL have port s_last  input  1  meaning the current beat is the final beat of a tile.
REQ-009 SHALL have port s_horiz  input  HORIZONTAL_BW*ARR_SIZE  meaning unskewed row operands; lane k at bits [k*HORIZONTAL_BW +: HORIZONTAL_BW].
REQ-010 SHALL have port s_vert  input  VERTICAL_BW*ARR_SIZE  meaning unskewed column operands; lane k at bits [k*VERTICAL_BW +: VERTICAL_BW].
REQ-011 SHALL have port horizontal_input  output  HORIZONTAL_BW*ARR_SIZE  meaning skewed row operands to the array.
REQ-012 SHALL have port vertical_input  output  VERTICAL_BW*ARR_SIZE  meaning skewed column operands to the array.
REQ-013 SHALL have port o_busy  output  1  meaning FSM is not IDLE.
REQ-014 SHALL have port o_done  output  1  meaning one-cycle pulse when a tile has fully drained into the array.
REQ-015 SHALL have port o_beat_cnt  output  16  meaning beats accepted in the current or most recent tile.

Function
REQ-016 SHALL implement FSM states IDLE, STREAM, FLUSH.
REQ-017 SHALL assert s_ready combinationally in IDLE and STREAM and deassert it in FLUSH; a beat is accepted iff s_valid && s_ready.
REQ-018 SHALL transition IDLE->STREAM on an accepted beat with s_last=0, IDLE->FLUSH on an accepted beat with s_last=1, STREAM->FLUSH on an accepted beat with s_last=1, and FLUSH->IDLE after exactly ARR_SIZE FLUSH cycles.
REQ-019 SHALL delay lane k (both horizontal and vertical) by k+1 register stages, so lane k of an accepted beat appears on the outputs k+1 cycles after acceptance.
REQ-020 SHALL advance every skew register on every cycle with no stall path, since the array has no back-pressure.
REQ-021 SHALL inject all-zero data into the lane-0 stage of each lane on any cycle without an accepted beat (bubble in STREAM, or any FLUSH/IDLE cycle), so that bubbles contribute zero to the MAC.
REQ-022 SHALL pulse o_done for one cycle on the final FLUSH cycle, when lane ARR_SIZE-1 of the last beat is on the outputs.
REQ-023 SHALL clear o_beat_cnt to 1 on the first accepted beat of a tile, increment it on each further accepted beat, saturate it at 65535, and hold it in IDLE until the next tile starts.
REQ-024 SHALL count a beat with s_valid=1 and s_last=1 accepted in IDLE as a complete one-beat tile.
REQ-025 SHALL ignore s_last when s_valid=0.
REQ-026 SHALL ignore all inputs during FLUSH, with no acceptance.

Reset
REQ-027 SHALL, when rst=0 at a rising edge, set the FSM to IDLE, clear all skew registers to zero, drive horizontal_input=0, vertical_input=0, o_busy=0, o_done=0 and o_beat_cnt=0.
REQ-028 SHALL, when reset occurs mid-STREAM or mid-FLUSH, discard in-flight data without asserting o_done; s_ready SHALL be 1 on the first cycle after rst returns to 1.

Verification (ARR_SIZE=4, HORIZONTAL_BW=16, VERTICAL_BW=32)
REQ-029 SHALL verify a single beat: s_horiz={16'h4,16'h3,16'h2,16'h1} with s_last=1 accepted at cycle 0 -> lane0=1 at cycle 1, lane1=2 at cycle 2, lane2=3 at cycle 3, lane3=4 at cycle 4, o_done at cycle 4, o_beat_cnt=1, all other outputs 0.
REQ-030 SHALL verify a 3-beat tile with a bubble (valid, gap, valid, valid+last) -> a zero slot appears in each lane, offset by lane index, o_beat_cnt=3, and o_done arrives 4 cycles after the last acceptance.
REQ-031 SHALL verify that s_valid held high through FLUSH gives s_ready=0 for exactly 4 cycles and that the next beat is accepted the cycle after o_done.
REQ-032 SHALL verify that rst=0 asserted in the cycle after two STREAM beats gives all outputs 0 on the next cycle, no o_done, and o_beat_cnt=0.
REQ-033 SHALL verify that a 65540-beat tile gives o_beat_cnt saturated at 65535.
REQ-034 SHALL verify that with s_vert lanes all 32'hFFFFFFFF for one beat, each vertical lane k is nonzero only at cycle k+1.
